mod_split_if_sched: RTL and testbench

- Scheduler that shares one conditional-update datapath between NREQ requesters.
- Datapath computes a two-register result pair: a = cond ? d : d-1; b = cond ? d+3 : d-2.
- Round-robin arbiter grants one requester at a time. A 3-state FSM sequences accept, execute and respond, and returns tagged results over a valid/ready channel.
- Sits between the requester clients and the registered split-if update stage.

---
 rtl/mod_split_if_sched_pkg.sv | 15 +
 rtl/mod_split_if_rr_arb.sv | 33 +++
 rtl/mod_split_if_sched.sv | 103 ++++++++++
 tb/tb_mod_split_if_sched.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/mod_split_if_sched_pkg.sv
// Shared types and constants for the split-if request scheduler.
package mod_split_if_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int B_ADD_T = 3;
    localparam int A_SUB_F = 1;
    localparam int B_SUB_F = 2;
    localparam int STATS_W = 16;

endpackage

// File: rtl/mod_split_if_rr_arb.sv
// Combinational round-robin arbiter: the search starts one above ptr and wraps.
module mod_split_if_rr_arb #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    input  logic            en,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_id,
    output logic            any
);

    logic           found;
    logic [IDW-1:0] idx;

    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        idx    = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = IDW'((int'(ptr) + k) % NREQ);
            if (!found && req[idx]) begin
                found  = 1'b1;
                gnt_id = idx;
            end
        end
        any = en && found;
        if (any) gnt[gnt_id] = 1'b1;
    end

endmodule

// File: rtl/mod_split_if_sched.sv
// Shares one split-if update datapath between NREQ requesters.
// Optional SPLIT_IF_SCHED_STATS_EN adds a saturating done_cnt output.
module mod_split_if_sched
    import mod_split_if_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int W    = 8,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] req_valid,
    output logic [NREQ-1:0] req_ready,
    input  logic [NREQ-1:0] req_cond,
    input  logic [NREQ*W-1:0] req_data,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [IDW-1:0]  rsp_id,
    output logic [W-1:0]    rsp_a,
    output logic [W-1:0]    rsp_b,
    output logic            busy
`ifdef SPLIT_IF_SCHED_STATS_EN
    ,
    output logic [STATS_W-1:0] done_cnt
`endif
);

    state_t         state;
    logic [IDW-1:0] ptr;
    logic           lat_cond;
    logic [W-1:0]   lat_data;
    logic [IDW-1:0] lat_id;
    logic [IDW-1:0] gnt_id;
    logic           any;
    logic [W-1:0]   a_nxt;
    logic [W-1:0]   b_nxt;

    mod_split_if_rr_arb #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req    (req_valid),
        .ptr    (ptr),
        .en     (state == IDLE),
        .gnt    (req_ready),
        .gnt_id (gnt_id),
        .any    (any)
    );

    assign a_nxt = lat_cond ? lat_data : lat_data - W'(A_SUB_F);
    assign b_nxt = lat_cond ? lat_data + W'(B_ADD_T)
                            : lat_data - W'(B_SUB_F);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            ptr       <= IDW'(NREQ - 1);
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_a     <= '0;
            rsp_b     <= '0;
            busy      <= 1'b0;
            lat_cond  <= 1'b0;
            lat_data  <= '0;
            lat_id    <= '0;
        end else begin
            unique case (state)
                IDLE: if (any) begin
                    lat_cond <= req_cond[gnt_id];
                    lat_data <= req_data[int'(gnt_id)*W +: W];
                    lat_id   <= gnt_id;
                    busy     <= 1'b1;
                    state    <= EXEC;
                end
                EXEC: begin
                    rsp_a     <= a_nxt;
                    rsp_b     <= b_nxt;
                    rsp_id    <= lat_id;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: if (rsp_ready) begin
                    ptr       <= lat_id;
                    rsp_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SPLIT_IF_SCHED_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            done_cnt <= '0;
        end else if (rsp_valid && rsp_ready && done_cnt != '1) begin
            done_cnt <= done_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mod_split_if_sched.sv
// Directed plus randomized bench for mod_split_if_sched against a queue-free model.
module tb_mod_split_if_sched;

    localparam int NREQ = 4;
    localparam int W    = 8;
    localparam int IDW  = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic [NREQ-1:0] req_valid;
    logic [NREQ-1:0] req_ready;
    logic [NREQ-1:0] req_cond;
    logic [NREQ*W-1:0] req_data;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [IDW-1:0]  rsp_id;
    logic [W-1:0]    rsp_a;
    logic [W-1:0]    rsp_b;
    logic            busy;
`ifdef SPLIT_IF_SCHED_STATS_EN
    logic [15:0]     done_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int m_ptr;
    int m_done;

    always #5 clk = ~clk;

    mod_split_if_sched #(.NREQ(NREQ), .W(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_cond  (req_cond),
        .req_data  (req_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_a     (rsp_a),
        .rsp_b     (rsp_b),
        .busy      (busy)
`ifdef SPLIT_IF_SCHED_STATS_EN
        ,
        .done_cnt  (done_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [NREQ-1:0] v, input int p);
        for (int k = 1; k <= NREQ; k++)
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        return -1;
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One full transaction; hold = cycles of rsp_ready low in RESP.
    task automatic txn(input logic [3:0] v, input logic [3:0] c,
                       input logic [31:0] d, input int hold);
        int g;
        logic [7:0] dv, ea, eb;
        req_valid = v;
        req_cond  = c;
        req_data  = d;
        rsp_ready = (hold == 0);
        #1;
        g = pick(v, m_ptr);
        if (g < 0) begin
            chk("idle_ready", 32'(req_ready), 0);
            step();
            chk("idle_busy", 32'(busy), 0);
            return;
        end
        chk("grant", 32'(req_ready), 32'(1) << g);
        dv = d[g*8 +: 8];
        ea = c[g] ? dv : dv - 8'd1;
        eb = c[g] ? dv + 8'd3 : dv - 8'd2;
        step();
        chk("exec_ready", 32'(req_ready), 0);
        chk("exec_valid", 32'(rsp_valid), 0);
        chk("exec_busy", 32'(busy), 1);
        step();
        for (int h = 0; h <= hold; h++) begin
            if (h == hold) rsp_ready = 1'b1;
            #1;
            chk("rsp_valid", 32'(rsp_valid), 1);
            chk("rsp_id", 32'(rsp_id), 32'(g));
            chk("rsp_a", 32'(rsp_a), 32'(ea));
            chk("rsp_b", 32'(rsp_b), 32'(eb));
            chk("resp_ready", 32'(req_ready), 0);
            step();
        end
        m_ptr = g;
        m_done++;
        chk("post_valid", 32'(rsp_valid), 0);
        chk("post_a", 32'(rsp_a), 32'(ea));
`ifdef SPLIT_IF_SCHED_STATS_EN
        chk("done_cnt", 32'(done_cnt), 32'(m_done > 65535 ? 65535 : m_done));
`endif
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        req_cond  = '0;
        req_data  = '0;
        rsp_ready = 1'b0;
        m_ptr     = NREQ - 1;
        m_done    = 0;
        step();
        step();
        reset = 1'b0;
        #1;
        chk("rst_valid", 32'(rsp_valid), 0);
        chk("rst_id", 32'(rsp_id), 0);
        chk("rst_a", 32'(rsp_a), 0);
        chk("rst_b", 32'(rsp_b), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ready", 32'(req_ready), 0);
        step();

        txn(4'b0001, 4'b0001, 32'h0000_0010, 0);
        txn(4'b0001, 4'b0000, 32'h0000_0000, 0);
        txn(4'b0001, 4'b0001, 32'h0000_00FF, 0);
        txn(4'b0110, 4'b0100, 32'h0033_4455, 5);
        txn(4'b0000, 4'b0000, 32'h0, 0);

        // Reset while EXEC is in flight must discard the transaction.
        req_valid = 4'b0100;
        req_cond  = 4'b0000;
        req_data  = 32'h0022_0000;
        step();
        chk("abort_busy", 32'(busy), 1);
        reset = 1'b1;
        req_valid = '0;
        step();
        reset = 1'b0;
        #1;
        chk("abort_valid", 32'(rsp_valid), 0);
        chk("abort_a", 32'(rsp_a), 0);
        chk("abort_b", 32'(rsp_b), 0);
        chk("abort_busy0", 32'(busy), 0);
        m_ptr  = NREQ - 1;
        m_done = 0;
        step();
        chk("abort_norsp", 32'(rsp_valid), 0);

        for (int i = 0; i < 5; i++)
            txn(4'b1111, 4'(i), 32'h1234_5678 + 32'(i), 0);

        for (int i = 0; i < 40; i++)
            txn(4'($urandom), 4'($urandom), $urandom, int'($urandom_range(0, 2)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
